// File: rtl/reorder_buffer.sv
// In-order retirement queue: allocates rename tags, collects CDB results, commits in program order.
// Optional ROB_FLUSH_EN: a committed mispredicted branch flushes the whole buffer and redirects the PC.
module reorder_buffer #(
  parameter int ROB_DEPTH = 16,
  parameter int IDX_W     = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             alloc_valid,
  input  logic [4:0]       alloc_rd,
  output logic             alloc_ready,
  output logic [IDX_W-1:0] alloc_tag,
  input  logic             wb_valid,
  input  logic [IDX_W-1:0] wb_tag,
  input  logic [31:0]      wb_value,
  input  logic             wb_mispredict,
  input  logic [31:0]      wb_target,
  input  logic [IDX_W-1:0] q1_tag,
  input  logic [IDX_W-1:0] q2_tag,
  output logic             q1_ready,
  output logic             q2_ready,
  output logic [31:0]      q1_value,
  output logic [31:0]      q2_value,
  output logic             commit_valid,
  output logic [4:0]       rob_commit_index,
  output logic [IDX_W-1:0] rob_commit_rename,
  output logic [31:0]      rob_commit_value,
  output logic             flush_out,
  output logic [31:0]      flush_pc,
  output logic             empty
);

  logic [ROB_DEPTH-1:0] busy;
  logic [ROB_DEPTH-1:0] ready;
  logic [4:0]           rd_mem    [ROB_DEPTH];
  logic [31:0]          value_mem [ROB_DEPTH];
  logic [IDX_W-1:0]     head;
  logic [IDX_W-1:0]     tail;
  logic [IDX_W:0]       count;
  logic                 do_alloc;
  logic                 do_wb;
  logic                 do_commit;
  logic                 do_flush;
  logic [31:0]          flush_pc_next;

  // alloc_ready looks only at the registered count, so a full buffer never reuses a slot freed this edge
  assign alloc_ready = (count < (IDX_W+1)'(ROB_DEPTH));
  assign alloc_tag   = tail;
  assign empty       = (count == '0);
  assign do_alloc    = alloc_valid && alloc_ready;
  assign do_wb       = wb_valid && busy[wb_tag];
  assign do_commit   = busy[head] && ready[head];

`ifdef ROB_FLUSH_EN
  logic [ROB_DEPTH-1:0] mispredict;
  logic [31:0]          target_mem [ROB_DEPTH];

  assign do_flush      = do_commit && mispredict[head];
  assign flush_pc_next = do_flush ? target_mem[head] : '0;
`else
  logic unused_flush;

  assign do_flush      = 1'b0;
  assign flush_pc_next = '0;
  assign unused_flush  = ^{wb_mispredict, wb_target};
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head              <= '0;
      tail              <= '0;
      count             <= '0;
      busy              <= '0;
      ready             <= '0;
      commit_valid      <= 1'b0;
      rob_commit_index  <= '0;
      rob_commit_rename <= '0;
      rob_commit_value  <= '0;
      flush_out         <= 1'b0;
      flush_pc          <= '0;
    end else if (rdy) begin
      commit_valid      <= do_commit;
      rob_commit_index  <= do_commit ? rd_mem[head] : '0;
      rob_commit_rename <= do_commit ? head : '0;
      rob_commit_value  <= do_commit ? value_mem[head] : '0;
      flush_out         <= do_flush;
      flush_pc          <= flush_pc_next;
      if (do_flush) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
        busy  <= '0;
        ready <= '0;
      end else begin
        if (do_wb) ready[wb_tag] <= 1'b1;
        if (do_commit) begin
          busy[head]  <= 1'b0;
          ready[head] <= 1'b0;
          head        <= head + IDX_W'(1);
        end
        if (do_alloc) begin
          busy[tail]  <= 1'b1;
          ready[tail] <= 1'b0;
          tail        <= tail + IDX_W'(1);
        end
        if (do_alloc && !do_commit)
          count <= count + (IDX_W+1)'(1);
        else if (!do_alloc && do_commit)
          count <= count - (IDX_W+1)'(1);
      end
    end
  end

  // payload storage needs no reset: it is only read behind busy/ready
  always_ff @(posedge clk) begin
    if (rdy) begin
      if (do_alloc) rd_mem[tail] <= alloc_rd;
      if (do_wb) begin
        value_mem[wb_tag] <= wb_value;
`ifdef ROB_FLUSH_EN
        mispredict[wb_tag] <= wb_mispredict;
        target_mem[wb_tag] <= wb_target;
`endif
      end
    end
  end

  function automatic logic [32:0] query(input logic [IDX_W-1:0] tag);
    logic [32:0] res;
    res = '0;
    if (busy[tag]) begin
      if (wb_valid && wb_tag == tag) res = {1'b1, wb_value};
      else if (ready[tag])           res = {1'b1, value_mem[tag]};
    end
    return res;
  endfunction

  always_comb begin
    {q1_ready, q1_value} = query(q1_tag);
    {q2_ready, q2_value} = query(q2_tag);
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer: directed scenarios plus randomized traffic against a queue-level model.
`timescale 1ns/1ps
module tb_reorder_buffer;
  localparam int D = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rdy = 1'b1;
  logic        alloc_valid = 1'b0;
  logic [4:0]  alloc_rd = '0;
  logic        alloc_ready;
  logic [3:0]  alloc_tag;
  logic        wb_valid = 1'b0;
  logic [3:0]  wb_tag = '0;
  logic [31:0] wb_value = '0;
  logic        wb_mispredict = 1'b0;
  logic [31:0] wb_target = '0;
  logic [3:0]  q1_tag = '0;
  logic [3:0]  q2_tag = '0;
  logic        q1_ready, q2_ready;
  logic [31:0] q1_value, q2_value;
  logic        commit_valid;
  logic [4:0]  rob_commit_index;
  logic [3:0]  rob_commit_rename;
  logic [31:0] rob_commit_value;
  logic        flush_out;
  logic [31:0] flush_pc;
  logic        empty;

  int total = 0;
  int bad = 0;

  reorder_buffer #(.ROB_DEPTH(D), .IDX_W(4)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .alloc_valid(alloc_valid), .alloc_rd(alloc_rd), .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
    .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_value(wb_value),
    .wb_mispredict(wb_mispredict), .wb_target(wb_target),
    .q1_tag(q1_tag), .q2_tag(q2_tag), .q1_ready(q1_ready), .q2_ready(q2_ready),
    .q1_value(q1_value), .q2_value(q2_value),
    .commit_valid(commit_valid), .rob_commit_index(rob_commit_index),
    .rob_commit_rename(rob_commit_rename), .rob_commit_value(rob_commit_value),
    .flush_out(flush_out), .flush_pc(flush_pc), .empty(empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: entries held as a circular queue described by head and occupancy
  bit          m_busy  [D];
  bit          m_ready [D];
  bit          m_mis   [D];
  logic [4:0]  m_rd    [D];
  logic [31:0] m_val   [D];
  logic [31:0] m_tgt   [D];
  int          m_head, m_count;
  logic        e_cv, e_fl;
  logic [4:0]  e_idx;
  logic [3:0]  e_ren;
  logic [31:0] e_val, e_fpc;
  logic [32:0] qe;

  task automatic model_reset();
    for (int i = 0; i < D; i++) begin
      m_busy[i] = 0;
      m_ready[i] = 0;
    end
    m_head = 0; m_count = 0;
    e_cv = 0; e_idx = 0; e_ren = 0; e_val = 0; e_fl = 0; e_fpc = 0;
  endtask

  task automatic model_step();
    bit commit, alloc, fl;
    int h, t;
    if (!rdy) return;
    h = m_head;
    t = (m_head + m_count) % D;
    commit = m_busy[h] && m_ready[h];
    alloc  = alloc_valid && (m_count < D);
    e_cv  = commit;
    e_idx = commit ? m_rd[h] : 5'd0;
    e_ren = commit ? 4'(h) : 4'd0;
    e_val = commit ? m_val[h] : 32'd0;
    fl = 0;
`ifdef ROB_FLUSH_EN
    fl = commit && m_mis[h];
`endif
    e_fl  = fl;
    e_fpc = fl ? m_tgt[h] : 32'd0;
    if (fl) begin
      for (int i = 0; i < D; i++) m_busy[i] = 0;
      m_head = 0; m_count = 0;
      return;
    end
    if (wb_valid && m_busy[wb_tag]) begin
      m_ready[wb_tag] = 1;
      m_val[wb_tag] = wb_value;
      m_mis[wb_tag] = wb_mispredict;
      m_tgt[wb_tag] = wb_target;
    end
    if (commit) begin
      m_busy[h] = 0;
      m_head = (h + 1) % D;
      m_count--;
    end
    if (alloc) begin
      m_busy[t] = 1;
      m_ready[t] = 0;
      m_rd[t] = alloc_rd;
      m_count++;
    end
  endtask

  function automatic logic [32:0] model_query(input logic [3:0] t);
    if (!m_busy[t]) return 33'd0;
    if (wb_valid && wb_tag == t) return {1'b1, wb_value};
    if (m_ready[t]) return {1'b1, m_val[t]};
    return 33'd0;
  endfunction

  always @(negedge clk) begin
    if (rst) model_reset();
    chk("commit_valid", commit_valid, e_cv);
    chk("commit_index", rob_commit_index, e_idx);
    chk("commit_rename", rob_commit_rename, e_ren);
    chk("commit_value", rob_commit_value, e_val);
    chk("flush_out", flush_out, e_fl);
    chk("flush_pc", flush_pc, e_fpc);
    chk("empty", empty, m_count == 0);
    chk("alloc_ready", alloc_ready, m_count < D);
    chk("alloc_tag", alloc_tag, (m_head + m_count) % D);
    qe = model_query(q1_tag);
    chk("q1", {q1_ready, q1_value}, qe);
    qe = model_query(q2_tag);
    chk("q2", {q2_ready, q2_value}, qe);
    if (!rst) model_step();
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    alloc_valid = 0; wb_valid = 0; wb_mispredict = 0; rdy = 1;
    step();
    rst = 1'b0;
  endtask

  task automatic alloc_n(input int n, input int rd_base);
    for (int i = 0; i < n; i++) begin
      alloc_valid = 1; alloc_rd = 5'(rd_base + i);
      step();
    end
    alloc_valid = 0;
  endtask

  task automatic wb(input logic [3:0] t, input logic [31:0] v);
    wb_valid = 1; wb_tag = t; wb_value = v;
    step();
    wb_valid = 0;
  endtask

  int cand[$];
  int r;
  logic [3:0] rt;

  initial begin
    step();
    rst = 1'b0;

    // single alloc / writeback / commit
    alloc_n(1, 5);
    wb(4'd0, 32'hDEADBEEF);
    step();
    chk("t2_cv", commit_valid, 1'b1);
    chk("t2_idx", rob_commit_index, 5'd5);
    chk("t2_ren", rob_commit_rename, 4'd0);
    chk("t2_val", rob_commit_value, 32'hDEADBEEF);
    step();
    chk("t2_idle_idx", rob_commit_index, 5'd0);
    chk("t2_idle_cv", commit_valid, 1'b0);

    // out-of-order writeback, in-order commit
    do_reset();
    alloc_n(3, 1);
    wb(4'd2, 32'h102);
    wb(4'd0, 32'h100);
    chk("t3_no_commit_yet", commit_valid, 1'b0);
    wb(4'd1, 32'h101);
    chk("t3_c0", {commit_valid, rob_commit_rename}, {1'b1, 4'd0});
    step();
    chk("t3_c1", {commit_valid, rob_commit_rename, rob_commit_value}, {1'b1, 4'd1, 32'h101});
    step();
    chk("t3_c2", {commit_valid, rob_commit_rename, rob_commit_index}, {1'b1, 4'd2, 5'd3});
    step();
    chk("t3_empty", empty, 1'b1);

    // full buffer, refused alloc during commit, wrap
    do_reset();
    alloc_n(16, 0);
    chk("t4_full_ready", alloc_ready, 1'b0);
    chk("t4_full_tag", alloc_tag, 4'd0);
    alloc_valid = 1; alloc_rd = 5'd31;
    step();
    chk("t4_refused_tag", alloc_tag, 4'd0);
    alloc_valid = 0;
    wb(4'd0, 32'h55);
    alloc_valid = 1; alloc_rd = 5'd9;
    step();
    chk("t4_commit", {commit_valid, rob_commit_rename}, {1'b1, 4'd0});
    chk("t4_after_ready", alloc_ready, 1'b1);
    chk("t4_after_tag", alloc_tag, 4'd0);
    step();
    alloc_valid = 0;
    chk("t4_wrap_tag", alloc_tag, 4'd1);
    chk("t4_wrap_full", alloc_ready, 1'b0);

    // query bypass, then stall with rdy low
    q1_tag = 4'd3; q2_tag = 4'd4;
    wb_valid = 1; wb_tag = 4'd3; wb_value = 32'h1234;
    #1;
    chk("t5_byp_ready", q1_ready, 1'b1);
    chk("t5_byp_value", q1_value, 32'h1234);
    chk("t5_q2_pending", {q2_ready, q2_value}, 33'd0);
    step();
    wb_valid = 0;
    chk("t5_stored", {q1_ready, q1_value}, {1'b1, 32'h1234});
    wb(4'd1, 32'h77);
    step();
    chk("t5_commit1", {commit_valid, rob_commit_rename, rob_commit_value}, {1'b1, 4'd1, 32'h77});
    rdy = 0; alloc_valid = 1; alloc_rd = 5'd12;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t5_stall_commit", {commit_valid, rob_commit_rename}, {1'b1, 4'd1});
      chk("t5_stall_tag", {alloc_ready, alloc_tag}, {1'b1, 4'd1});
    end
    rdy = 1; alloc_valid = 0;
    step();

    // asynchronous reset while entries are busy and a commit is showing
    do_reset();
    alloc_n(3, 4);
    wb(4'd0, 32'hABC);
    step();
    chk("t1_pre_cv", commit_valid, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("t1_empty", empty, 1'b1);
    chk("t1_tag", alloc_tag, 4'd0);
    chk("t1_cv", commit_valid, 1'b0);
    step();
    rst = 1'b0;

    // mispredicted branch at head
    do_reset();
    alloc_n(2, 7);
    wb_mispredict = 1; wb_target = 32'h100;
    wb(4'd0, 32'hAA);
    wb_mispredict = 0;
    step();
    chk("t6_commit0", {commit_valid, rob_commit_rename, rob_commit_index}, {1'b1, 4'd0, 5'd7});
`ifdef ROB_FLUSH_EN
    chk("t6_flush", {flush_out, flush_pc}, {1'b1, 32'h100});
    chk("t6_empty", empty, 1'b1);
`else
    chk("t6_noflush", {flush_out, flush_pc}, 33'd0);
    chk("t6_not_empty", empty, 1'b0);
`endif
    wb(4'd1, 32'hBB);
    step();
`ifdef ROB_FLUSH_EN
    chk("t6_no_commit1", commit_valid, 1'b0);
`else
    chk("t6_commit1", {commit_valid, rob_commit_rename, rob_commit_value}, {1'b1, 4'd1, 32'hBB});
`endif

    // randomized traffic
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      rdy = ($urandom_range(0, 9) != 0);
      alloc_valid = $urandom_range(0, 1);
      alloc_rd = 5'($urandom);
      wb_valid = 0;
      cand.delete();
      for (int t = 0; t < D; t++) if (m_busy[t] && !m_ready[t]) cand.push_back(t);
      r = $urandom_range(0, 9);
      if (r < 6 && cand.size() > 0) begin
        wb_valid = 1;
        wb_tag = 4'(cand[$urandom_range(0, cand.size() - 1)]);
      end else if (r < 8) begin
        rt = 4'($urandom);
        if (!m_busy[rt]) begin
          wb_valid = 1;
          wb_tag = rt;
        end
      end
      wb_value = $urandom;
      wb_mispredict = ($urandom_range(0, 29) == 0);
      wb_target = $urandom;
      q1_tag = $urandom_range(0, 1) ? wb_tag : 4'($urandom);
      q2_tag = 4'($urandom);
      step();
    end
    rdy = 1; alloc_valid = 0; wb_valid = 0;
    step();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
